// File: rtl/counter_wb_ctrl.sv
// Wishbone-controlled prescaler and control block for an external counter.
// Provides tick/load/direction to the counter and a latched wrap interrupt.
module counter_wb_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          CNT_W     = 4,
    parameter int          PRESC_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [3:0]       wbs_sel_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [CNT_W-1:0] count_i,
    output logic             tick_o,
    output logic             dir_o,
    output logic             load_o,
    output logic [CNT_W-1:0] load_val_o,
    output logic             irq_o
);

    logic               ctrl_en;
    logic               ctrl_dir;
    logic               ctrl_ien;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic               wrap;

    logic               hit;
    logic               acc;
    logic               wr;
    logic [1:0]         reg_sel;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_load;
    logic               clr_wrap;
    logic               due;
    logic               wrap_set;
    logic [31:0]        lane_mask;
    logic [PRESC_W-1:0] presc_next;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign hit = wbs_cyc_i & wbs_stb_i
               & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    // An access is accepted only when no ack is currently showing,
    // which enforces at most one access every two cycles.
    assign acc      = hit & ~wbs_ack_o;
    assign wr       = acc & wbs_we_i;
    assign reg_sel  = wbs_adr_i[3:2];
    assign wr_ctrl  = wr & (reg_sel == 2'd0) & wbs_sel_i[0];
    assign wr_presc = wr & (reg_sel == 2'd1);
    assign wr_load  = wr & (reg_sel == 2'd2) & wbs_sel_i[0];
    assign clr_wrap = wr & (reg_sel == 2'd3) & wbs_sel_i[1]
                    & wbs_dat_i[8];

    assign lane_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                         {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign presc_next = (presc & ~lane_mask[PRESC_W-1:0])
                      | (wbs_dat_i[PRESC_W-1:0] & lane_mask[PRESC_W-1:0]);

    // Greater-or-equal so a lowered PRESCALE fires at once, never wraps.
    assign due = ctrl_en & (presc_cnt >= presc);

    assign wrap_set = tick_o & (ctrl_dir ? (count_i == '0) : (&count_i));

    assign dir_o = ctrl_dir;
    assign irq_o = wrap & ctrl_ien;

    assign unused_bits = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i, lane_mask};

    // Read mux for the four registers.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            2'd0: rdata[2:0] = {ctrl_ien, ctrl_dir, ctrl_en};
            2'd1: rdata[PRESC_W-1:0] = presc;
            2'd2: rdata[CNT_W-1:0] = load_val_o;
            2'd3: begin
                rdata[CNT_W-1:0] = count_i;
                rdata[8]         = wrap;
            end
        endcase
    end

    // Bus handshake: registered ack, read data only alongside ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
        end
    end

    // Control and prescale registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ctrl_en  <= 1'b0;
            ctrl_dir <= 1'b0;
            ctrl_ien <= 1'b0;
            presc    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en  <= wbs_dat_i[0];
                ctrl_dir <= wbs_dat_i[1];
                ctrl_ien <= wbs_dat_i[2];
            end
            if (wr_presc) begin
                presc <= presc_next;
            end
        end
    end

    // Load strobe and held load value.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            load_o     <= 1'b0;
            load_val_o <= '0;
        end else begin
            load_o <= wr_load;
            if (wr_load) begin
                load_val_o <= wbs_dat_i[CNT_W-1:0];
            end
        end
    end

    // Prescaler; a coinciding load swallows the tick and restarts it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            presc_cnt <= '0;
            tick_o    <= 1'b0;
        end else if (!ctrl_en) begin
            presc_cnt <= '0;
            tick_o    <= 1'b0;
        end else if (due) begin
            presc_cnt <= '0;
            tick_o    <= ~wr_load;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
            tick_o    <= 1'b0;
        end
    end

    // Wrap flag: a new wrap beats a simultaneous clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_set | (wrap & ~clr_wrap);
        end
    end

endmodule

// File: tb/tb_counter_wb_ctrl.sv
// Randomized bench for counter_wb_ctrl against a behavioural model.
// Inputs change on the falling edge; outputs are checked there too.
module tb_counter_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic [3:0]  count = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        tick;
    logic        dir;
    logic        load;
    logic [3:0]  lval;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    bit          m_en, m_dir, m_ien, m_wrap;
    bit          m_ack, m_tick, m_load;
    logic [15:0] m_presc;
    logic [3:0]  m_lval;
    logic [31:0] m_dat;
    int          m_phase;

    always #5 clk = ~clk;

    counter_wb_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat),
        .wbs_sel_i  (sel),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .count_i    (count),
        .tick_o     (tick),
        .dir_o      (dir),
        .load_o     (load),
        .load_val_o (lval),
        .irq_o      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_dir = 0; m_ien = 0; m_wrap = 0;
        m_ack = 0; m_tick = 0; m_load = 0;
        m_presc = '0; m_lval = '0; m_dat = '0; m_phase = 0;
    endtask

    // One rising edge of the specified behaviour, from pre-edge state.
    task automatic model_step();
        logic [31:0] rv;
        logic [1:0]  rs;
        bit hit, acc, wr, due, ld, ws, clr;
        hit = cyc && stb && (adr[31:4] == BASE[31:4]);
        rs  = adr[3:2];
        acc = hit && !m_ack;
        wr  = acc && we;
        case (rs)
            2'd0: rv = {29'b0, m_ien, m_dir, m_en};
            2'd1: rv = {16'b0, m_presc};
            2'd2: rv = {28'b0, m_lval};
            default: rv = {23'b0, m_wrap, 4'b0, count};
        endcase
        due = m_en && (m_phase >= int'(m_presc));
        ld  = wr && rs == 2'd2 && sel[0];
        ws  = m_tick && (m_dir ? count == 4'h0 : count == 4'hF);
        clr = wr && rs == 2'd3 && sel[1] && dat[8];
        m_wrap  = ws || (m_wrap && !clr);
        m_tick  = due && !ld;
        m_phase = (!m_en || due) ? 0 : m_phase + 1;
        m_load  = ld;
        if (ld) m_lval = dat[3:0];
        m_dat = (acc && !we) ? rv : '0;
        m_ack = acc;
        if (wr && rs == 2'd0 && sel[0]) begin
            m_en  = dat[0];
            m_dir = dat[1];
            m_ien = dat[2];
        end
        if (wr && rs == 2'd1) begin
            if (sel[0]) m_presc[7:0]  = dat[7:0];
            if (sel[1]) m_presc[15:8] = dat[15:8];
        end
    endtask

    task automatic compare_all();
        chk("ack", ack, m_ack);
        chk("dat_o", rdat, m_dat);
        chk("tick", tick, m_tick);
        chk("load", load, m_load);
        chk("load_val", lval, m_lval);
        chk("dir", dir, m_dir);
        chk("irq", irq, m_wrap && m_ien);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        cyc = 1; stb = 1; we = 1; adr = a; dat = d; sel = s;
        cycle();
        cyc = 0; stb = 0; we = 0;
        cycle();
    endtask

    task automatic drive_rand();
        int k;
        cyc = ($urandom_range(0, 9) < 7);
        stb = ($urandom_range(0, 9) < 8);
        we  = $urandom_range(0, 1);
        sel = 4'($urandom);
        k   = $urandom_range(0, 9);
        if (k < 8) adr = BASE + 32'(4 * (k % 4)) + 32'($urandom_range(0, 3));
        else if (k == 8) adr = BASE + 32'h10 + 32'($urandom_range(0, 15));
        else adr = $urandom;
        dat = $urandom;
        if ($urandom_range(0, 9) != 0) dat[15:9] = '0;
        if ($urandom_range(0, 9) < 7) dat[7:3] = '0;
        k = $urandom_range(0, 3);
        count = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'($urandom);
    endtask

    initial begin
        model_reset();
        #2 rst = 0;
        #1 compare_all();
        idle(2);
        rst = 1;
        idle(1);

        // Prescale 3: tick every 4 cycles after enabling.
        wb_write(BASE + 32'h4, 32'd3, 4'b0011);
        wb_write(BASE + 32'h0, 32'd1, 4'b0001);
        idle(12);

        // Counting up at all ones with prescale 0: wrap and irq.
        count = 4'hF;
        wb_write(BASE + 32'h4, 32'd0, 4'b0011);
        wb_write(BASE + 32'h0, 32'd5, 4'b0001);
        idle(3);
        wb_write(BASE + 32'hC, 32'h100, 4'b0010);
        count = 4'h7;
        idle(2);
        wb_write(BASE + 32'hC, 32'h100, 4'b0010);
        idle(2);

        // Load writes at every phase of a 4-cycle prescale.
        wb_write(BASE + 32'h4, 32'd3, 4'b0011);
        for (int i = 0; i < 6; i++) begin
            wb_write(BASE + 32'h8, 32'hA + 32'(i), 4'b0001);
            idle(i % 4);
        end

        // Held strobe: acks alternate; out-of-window address never acks.
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4;
        idle(6);
        adr = BASE + 32'h10;
        idle(4);
        cyc = 0; stb = 0;
        idle(1);

        // Lowering prescale below the running count.
        wb_write(BASE + 32'h4, 32'd100, 4'b0011);
        wb_write(BASE + 32'h0, 32'd1, 4'b0001);
        idle(46);
        wb_write(BASE + 32'h4, 32'd10, 4'b0001);
        idle(14);

        // Reset while ack is showing.
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h8; dat = 32'h5; sel = 4'hF;
        @(posedge clk);
        model_step();
        #2 rst = 0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        idle(2);
        rst = 1;
        idle(3);

        // Reset while an access is pending but not yet acked.
        cyc = 0; stb = 0;
        idle(1);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'hC;
        #2 rst = 0;
        #1 model_reset();
        compare_all();
        idle(1);
        rst = 1;
        idle(2);
        cyc = 0; stb = 0;
        idle(1);

        for (int i = 0; i < 4000; i++) begin
            drive_rand();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_wb_ctrl.md
COUNTER_WB_CTRL -- requirements
Module: counter_wb_ctrl

Interface
REQ-001 Parameter ADDR_BASE, 32'h3000_0000, Wishbone base address; bits [3:0] SHALL be ignored.
REQ-002 Parameter CNT_W, 4, width of the downstream counter value.
REQ-003 Parameter PRESC_W, 16, prescaler width.
REQ-004 Clocking SHALL be one clock and reset SHALL be asynchronous, active-low.
REQ-005 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-006 wb_rst_i  in  1  asynchronous active-low reset.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle/strobe/write.
REQ-008 wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data; wbs_sel_i  in  4  byte lanes.
REQ-009 wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-010 count_i  in  CNT_W  current value from the downstream counter.
REQ-011 tick_o  out  1  one-cycle count-enable pulse to the counter.
REQ-012 dir_o  out  1  0 = count up, 1 = count down.
REQ-013 load_o  out  1  one-cycle load strobe; load_val_o  out  CNT_W  load value.
REQ-014 irq_o  out  1  wrap interrupt, level.

Function
REQ-015 Hit SHALL be cyc&stb&(adr[31:4]==ADDR_BASE[31:4]); misses SHALL never produce ack.
REQ-016 Ack SHALL be registered: high the cycle after a hit, low the following cycle, with no ack on the cycle after an ack (one access per two cycles minimum).
REQ-017 Writes and read sampling SHALL take effect on the edge that raises ack; wbs_dat_o SHALL be 0 whenever ack is low.
REQ-018 Offset 0x0 CTRL (RW): bit0 EN, bit1 DIR, bit2 IRQ_EN; other bits read 0; written when sel[0].
REQ-019 Offset 0x4 PRESCALE (RW): [PRESC_W-1:0], byte lanes sel[0]/sel[1] honored individually.
REQ-020 Offset 0x8 LOAD: write with sel[0] SHALL pulse load_o one cycle (coincident with ack) and set load_val_o=wdata[CNT_W-1:0]; read returns last load value.
REQ-021 Offset 0xC STATUS: read [CNT_W-1:0]=count_i, bit8=WRAP; write with sel[1] and wdata[8]=1 SHALL clear WRAP.
REQ-022 Prescaler: with EN=1, presc_cnt SHALL increment each cycle; when presc_cnt >= PRESCALE, tick_o SHALL be high the next cycle and presc_cnt SHALL return to 0; tick period = PRESCALE+1 cycles.
REQ-023 PRESCALE=0 with EN=1 SHALL give tick_o high every cycle.
REQ-024 EN=0 SHALL hold presc_cnt at 0 and tick_o low; setting EN=1 SHALL produce the first tick PRESCALE+1 cycles after the write ack.
REQ-025 Lowering PRESCALE below presc_cnt SHALL cause a tick on the next cycle (>= compare), not a wrap through 2^PRESC_W.
REQ-026 Load and tick coinciding: load_o SHALL win, tick_o SHALL be suppressed that cycle, and presc_cnt SHALL restart at 0.
REQ-027 dir_o SHALL equal CTRL.DIR.
REQ-028 WRAP SHALL set when tick_o=1 and (DIR=0 and count_i=all ones, or DIR=1 and count_i=0).
REQ-029 Simultaneous WRAP set and clear SHALL leave WRAP=1.
REQ-030 irq_o SHALL equal WRAP & IRQ_EN.

Reset
REQ-031 On wb_rst_i low, immediately and independent of the clock: CTRL=0, PRESCALE=0, load value=0, WRAP=0, presc_cnt=0, wbs_ack_o=0, wbs_dat_o=0, tick_o=0, load_o=0, load_val_o=0, dir_o=0, irq_o=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ack; the first ack after release SHALL require a new hit.

Verification
REQ-033 Write PRESCALE=3, CTRL=1 -> tick_o pulses every 4 cycles, first pulse 4 cycles after the ack.
REQ-034 CTRL=0b101, count_i=15, PRESCALE=0 -> WRAP=1 and irq_o=1 on the cycle after the tick; write STATUS 0x100 -> irq_o=0 unless a new wrap occurs in the same cycle.
REQ-035 Write LOAD=0xA on a cycle where a tick is due -> load_o=1, load_val_o=0xA, tick_o=0, next tick PRESCALE+1 cycles later.
REQ-036 Hold cyc/stb high at 0x3000_0004 for 6 cycles -> acks on cycles 1, 3, 5 only; address 0x3000_0010 -> no ack.
REQ-037 PRESCALE=100, running, presc_cnt=50, write PRESCALE=10 -> tick on the cycle after the write ack.
REQ-038 Drop wb_rst_i during a pending access -> every output 0 immediately, no ack emitted.
